packet_gen: RTL and testbench

PACKET_GEN -- requirements
Module: packet_gen

---
 rtl/packet_gen.sv | 144 ++++++++++++++
 tb/tb_packet_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/packet_gen.sv
// USB-style low-speed packet serialiser: SYNC, NRZI-encoded bit-stuffed payload, SE0/SE0/J EOP.
// One line symbol per shift_enable tick; byte handshake via tx_data_valid / tx_data_ready.
module packet_gen #(
    parameter int unsigned STUFF_RUN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_enable,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_data_valid,
    output logic [1:0] USBdata,
    output logic       tx_data_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned OnesW = $clog2(STUFF_RUN + 1);
    localparam logic [OnesW-1:0] StuffMax = OnesW'(STUFF_RUN);
    localparam logic [1:0] SymJ   = 2'b10;
    localparam logic [1:0] SymSe0 = 2'b00;
    localparam logic [7:0] SyncByte = 8'h80;

    typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

    state_e           state;
    logic [1:0]       level;
    logic [OnesW-1:0] ones_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       sync_cnt;
    logic [7:0]       shreg;
    logic             last_q;
    logic             eop_pending;

    logic             cur_bit;
    logic [1:0]       bit_sym;

    // NRZI: a 1 holds the current level, a 0 toggles J<->K.
    always_comb begin
        cur_bit = (state == StSync) ? SyncByte[sync_cnt] : shreg[bit_idx];
        bit_sym = cur_bit ? level : ~level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            level         <= SymJ;
            ones_cnt      <= '0;
            bit_idx       <= '0;
            sync_cnt      <= '0;
            shreg         <= '0;
            last_q        <= 1'b0;
            eop_pending   <= 1'b0;
            USBdata       <= SymJ;
            tx_data_ready <= 1'b0;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            tx_data_ready <= 1'b0;
            tx_done       <= 1'b0;
            tx_err        <= 1'b0;
            unique case (state)
                StIdle: begin
                    USBdata <= SymJ;
                    if (tx_start) begin
                        shreg         <= tx_data;
                        last_q        <= tx_last;
                        tx_data_ready <= 1'b1;
                        tx_busy       <= 1'b1;
                        bit_idx       <= '0;
                        sync_cnt      <= '0;
                        state         <= StSync;
                    end
                end
                StSync: begin
                    if (shift_enable) begin
                        USBdata  <= bit_sym;
                        level    <= bit_sym;
                        ones_cnt <= cur_bit ? ones_cnt + OnesW'(1) : '0;
                        sync_cnt <= sync_cnt + 3'd1;
                        if (sync_cnt == 3'd7) begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (shift_enable) begin
                        if (ones_cnt == StuffMax) begin
                            // Stuff bit: forced toggle, payload position does not advance.
                            USBdata  <= ~level;
                            level    <= ~level;
                            ones_cnt <= '0;
                        end else if (eop_pending) begin
                            USBdata     <= SymSe0;
                            eop_pending <= 1'b0;
                            state       <= StEopSe0;
                        end else begin
                            USBdata  <= bit_sym;
                            level    <= bit_sym;
                            ones_cnt <= cur_bit ? ones_cnt + OnesW'(1) : '0;
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                if (last_q) begin
                                    eop_pending <= 1'b1;
                                end else if (tx_data_valid) begin
                                    shreg         <= tx_data;
                                    last_q        <= tx_last;
                                    tx_data_ready <= 1'b1;
                                end else begin
                                    tx_err      <= 1'b1;
                                    eop_pending <= 1'b1;
                                end
                            end
                        end
                    end
                end
                StEopSe0: begin
                    if (shift_enable) begin
                        USBdata <= SymSe0;
                        state   <= StEopJ;
                    end
                end
                StEopJ: begin
                    if (shift_enable) begin
                        USBdata  <= SymJ;
                        level    <= SymJ;
                        ones_cnt <= '0;
                        bit_idx  <= '0;
                        tx_done  <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// Directed vector bench for packet_gen: per-cycle table of inputs and expected outputs,
// plus hand sequences for reset behaviour.
module tb_packet_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shift_enable = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_data_valid = 1'b0;
    logic [1:0] USBdata;
    logic       tx_data_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;

    always #5 clk = ~clk;

    packet_gen #(.STUFF_RUN(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (shift_enable),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_data_valid(tx_data_valid),
        .USBdata      (USBdata),
        .tx_data_ready(tx_data_ready),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_err       (tx_err)
    );

    typedef struct {
        logic       se;
        logic       start;
        logic [7:0] data;
        logic       last;
        logic       valid;
        logic [1:0] usb;
        logic       rdy;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cur_data;
    logic       cur_last;
    logic       cur_valid;

    function automatic void tk(input logic se, input logic start, input logic [1:0] usb,
                               input logic rdy, input logic busy, input logic done,
                               input logic err);
        vec_t v;
        v.se = se; v.start = start; v.data = cur_data; v.last = cur_last; v.valid = cur_valid;
        v.usb = usb; v.rdy = rdy; v.busy = busy; v.done = done; v.err = err;
        vecs.push_back(v);
    endfunction

    // Ticks with busy=1 and no pulses; J/K/0 name the expected line symbol.
    function automatic void tks(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            logic [1:0] sym;
            c = s[i];
            sym = (c == "J") ? J : (c == "K") ? K : 2'b00;
            tk(1'b1, 1'b0, sym, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endfunction

    function automatic void eop();
        tks("00");
        tk(1'b1, 1'b0, J, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {usb,rdy,busy,done,err}=%b expected %b", name, got, exp);
        end
    endtask

    initial begin
        cur_data = 8'h00; cur_last = 1'b1; cur_valid = 1'b1;
        // 0x00 last; start coincides with a tick, J held on that edge.
        tk(1'b1, 1'b1, J, 1'b1, 1'b1, 1'b0, 1'b0);
        tks("KJKJKJKK");
        tks("JK");
        cur_data = 8'hFF;
        tk(1'b1, 1'b1, J, 1'b0, 1'b1, 1'b0, 1'b0);   // tx_start mid-DATA ignored
        tk(1'b0, 1'b1, J, 1'b0, 1'b1, 1'b0, 1'b0);   // no tick: symbol held
        tks("KJKJK");
        eop();
        tk(1'b1, 1'b0, J, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0xFF last: five K, stuffed J, three J.
        cur_data = 8'hFF; cur_last = 1'b1;
        tk(1'b0, 1'b1, J, 1'b1, 1'b1, 1'b0, 1'b0);
        tks("KJKJ");
        tk(1'b0, 1'b0, J, 1'b0, 1'b1, 1'b0, 1'b0);
        tks("KJKK");
        tks("KKKKKJJJJ");
        eop();

        // Restart on the cycle after tx_done: 0x01 then 0x02.
        cur_data = 8'h01; cur_last = 1'b0; cur_valid = 1'b1;
        tk(1'b0, 1'b1, J, 1'b1, 1'b1, 1'b0, 1'b0);
        cur_data = 8'h02; cur_last = 1'b1;
        tks("KJKJKJKK");
        tks("KJKJKJK");
        tk(1'b1, 1'b0, J, 1'b1, 1'b1, 1'b0, 1'b0);
        tks("KKJKJKJK");
        eop();
        tk(1'b1, 1'b0, J, 1'b0, 1'b0, 1'b0, 1'b0);

        // Underrun: not last, valid low at bit 7.
        cur_data = 8'h00; cur_last = 1'b0; cur_valid = 1'b1;
        tk(1'b0, 1'b1, J, 1'b1, 1'b1, 1'b0, 1'b0);
        cur_valid = 1'b0;
        tks("KJKJKJKK");
        tks("JKJKJKJ");
        tk(1'b1, 1'b0, K, 1'b0, 1'b1, 1'b0, 1'b1);
        eop();
        tk(1'b1, 1'b0, J, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0xFC last: sixth one lands on bit 7, stuff bit must precede EOP.
        cur_data = 8'hFC; cur_last = 1'b1; cur_valid = 1'b1;
        tk(1'b0, 1'b1, J, 1'b1, 1'b1, 1'b0, 1'b0);
        tks("KJKJKJKK");
        tks("JKKKKKKKJ");
        eop();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset", {USBdata, tx_data_ready, tx_busy, tx_done, tx_err}, {J, 4'b0000});
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            shift_enable  = vecs[i].se;
            tx_start      = vecs[i].start;
            tx_data       = vecs[i].data;
            tx_last       = vecs[i].last;
            tx_data_valid = vecs[i].valid;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {USBdata, tx_data_ready, tx_busy, tx_done, tx_err},
                  {vecs[i].usb, vecs[i].rdy, vecs[i].busy, vecs[i].done, vecs[i].err});
        end

        // Reset during SYNC: abandon immediately, no EOP, no tx_done.
        shift_enable = 1'b0; tx_start = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
        tx_data_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0; shift_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sync3", {USBdata, tx_data_ready, tx_busy, tx_done, tx_err}, {K, 4'b0100});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst", {USBdata, tx_data_ready, tx_busy, tx_done, tx_err}, {J, 4'b0000});
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d", c),
                  {USBdata, tx_data_ready, tx_busy, tx_done, tx_err}, {J, 4'b0000});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
